// File: rtl/sbus_mem_responder_pkg.sv
// rtl/sbus_mem_responder_pkg.sv - shared types, FSM states and parity helpers for the SBUS memory responder
package sbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK_WAIT,
    DATA_WAIT,
    XFER,
    RPW_PAUSE,
    DONE
  } sbus_state_e;

  typedef logic [14:35] sbus_adr_t;
  typedef logic [0:35]  sbus_word_t;
  typedef logic [0:3]   sbus_rq_t;

  // Parity bit that makes the word plus parity contain an odd number of ones
  function automatic logic odd_par36(input sbus_word_t d);
    return ~^d;
  endfunction

  // Same rule applied to the 22-bit word address
  function automatic logic odd_par22(input sbus_adr_t a);
    return ~^a;
  endfunction

endpackage

// File: rtl/sbus_mem_responder_if.sv
// rtl/sbus_mem_responder_if.sv - MBOX/SBUS request/response bundle with requestor and responder views
interface sbus_mem_responder_if;
  import sbus_pkg::*;

  logic       MEM_START;
  logic       MEM_RD_RQ;
  logic       MEM_WR_RQ;
  sbus_rq_t   RQ;
  sbus_adr_t  ADR;
  logic       ADR_PAR;
  sbus_word_t DATA_IN;
  logic       DATA_PAR_IN;
  sbus_word_t DATA_OUT;
  logic       DATA_PAR_OUT;
  logic       ACKN;
  logic       DATA_VALID;
  logic       MEM_ERROR;
  logic       MEM_ADR_PAR_ERR;
  logic       BUSY;

  modport master (
    output MEM_START, MEM_RD_RQ, MEM_WR_RQ, RQ, ADR, ADR_PAR, DATA_IN, DATA_PAR_IN,
    input  DATA_OUT, DATA_PAR_OUT, ACKN, DATA_VALID, MEM_ERROR, MEM_ADR_PAR_ERR, BUSY
  );

  modport slave (
    input  MEM_START, MEM_RD_RQ, MEM_WR_RQ, RQ, ADR, ADR_PAR, DATA_IN, DATA_PAR_IN,
    output DATA_OUT, DATA_PAR_OUT, ACKN, DATA_VALID, MEM_ERROR, MEM_ADR_PAR_ERR, BUSY
  );

endinterface

// File: rtl/sbus_mem_responder_mem_array.sv
// rtl/sbus_mem_responder_mem_array.sv - 37-bit word+parity storage, synchronous write, registered read
module sbus_mem_array #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [36:0]       wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [36:0]       rdata_o
);

  logic [36:0] mem_q [0:(1<<ADDR_W)-1];
  logic [36:0] rdata_q;

  // Write port; storage has no reset so contents survive a responder reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port; holds the last word read until the next enabled read
  always_ff @(posedge clk) begin
    if (!RESET)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sbus_mem_responder.sv
// rtl/sbus_mem_responder.sv - SBUS memory responder top; SBUS_RPW_EN enables read-pause-write
module sbus_mem_responder
  import sbus_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 14,
  parameter int ACKN_DLY       = 2,
  parameter int DATA_DLY       = 4
) (
  input logic                 clk,
  input logic                 RESET,
  sbus_mem_responder_if.slave bus
);

  localparam logic [20:0] QUAD_LIMIT = 21'(1) << (MEM_WORDS_LOG2 - 2);

  sbus_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        phase_q, phase_d;
  logic        rd_q, wr_q, adr_par_q, start_prev_q;
  sbus_rq_t    rq_q;
  sbus_adr_t   adr_q;
  logic        ackn_q, ackn_d, aperr_q, aperr_d;
  logic        dv_q, dv_d, dv_rd_q, dv_rd_d;
  logic        wr_pend_q, wr_pend_d;
  logic [MEM_WORDS_LOG2-1:0] wr_addr_q, arr_addr;
  logic        rd_en, nxm, par_bad, xfer_rd, xfer_wr;
  logic [1:0]  w;
  logic [36:0] rdata;
  sbus_word_t  rd_word;

  assign nxm      = {1'b0, bus.ADR[14:33]} >= QUAD_LIMIT;
  assign par_bad  = odd_par22(adr_q) != adr_par_q;
  assign w        = adr_q[34:35] + idx_q;
  assign arr_addr = {adr_q[36-MEM_WORDS_LOG2:33], w};

`ifdef SBUS_RPW_EN
  // Combined RD+WR: first pass reads, second pass (phase 1) writes
  assign xfer_rd = rd_q & ~phase_q;
  assign xfer_wr = wr_q & (~rd_q | phase_q);
`else
  // Combined RD+WR degrades to a plain read
  assign xfer_rd = rd_q & ~phase_q;
  assign xfer_wr = wr_q & ~rd_q;
`endif

  // Next-state and strobe decode; every slot in XFER is one clock whether requested or not
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    ackn_d    = 1'b0;
    aperr_d   = 1'b0;
    dv_d      = 1'b0;
    dv_rd_d   = 1'b0;
    wr_pend_d = 1'b0;
    rd_en     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        idx_d   = '0;
        phase_d = 1'b0;
        if (bus.MEM_START) state_d = nxm ? DONE : ACK_WAIT;
      end
      ACK_WAIT: begin
        if (cnt_q == 8'(ACKN_DLY - 1)) begin
          ackn_d  = 1'b1;
          aperr_d = par_bad;
          cnt_d   = '0;
          state_d = par_bad ? DONE : DATA_WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA_WAIT: begin
        if (cnt_q == 8'(DATA_DLY - 1)) begin
          idx_d   = '0;
          state_d = XFER;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      XFER: begin
        if (rq_q[w]) begin
          dv_d      = 1'b1;
          dv_rd_d   = xfer_rd;
          rd_en     = xfer_rd;
          wr_pend_d = xfer_wr;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
`ifdef SBUS_RPW_EN
          if (rd_q && wr_q && !phase_q) begin
            phase_d = 1'b1;
            state_d = RPW_PAUSE;
          end
`endif
        end
      end
      RPW_PAUSE: begin
        if (bus.MEM_START && !start_prev_q) begin
          idx_d   = '0;
          state_d = XFER;
        end
      end
      DONE: begin
        if (!bus.MEM_START) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered output strobes
  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      phase_q      <= 1'b0;
      start_prev_q <= 1'b0;
      ackn_q       <= 1'b0;
      aperr_q      <= 1'b0;
      dv_q         <= 1'b0;
      dv_rd_q      <= 1'b0;
      wr_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      start_prev_q <= bus.MEM_START;
      ackn_q       <= ackn_d;
      aperr_q      <= aperr_d;
      dv_q         <= dv_d;
      dv_rd_q      <= dv_rd_d;
      wr_pend_q    <= wr_pend_d;
    end
  end

  // Request capture in IDLE, and the address of a write slot whose data lands on the following edge
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.MEM_START) begin
      rd_q      <= bus.MEM_RD_RQ;
      wr_q      <= bus.MEM_WR_RQ;
      rq_q      <= bus.RQ;
      adr_q     <= bus.ADR;
      adr_par_q <= bus.ADR_PAR;
    end
    if (wr_pend_d) wr_addr_q <= arr_addr;
  end

  sbus_mem_array #(.ADDR_W(MEM_WORDS_LOG2)) u_array (
    .clk     (clk),
    .RESET   (RESET),
    .we_i    (wr_pend_q),
    .waddr_i (wr_addr_q),
    .wdata_i ({bus.DATA_IN, bus.DATA_PAR_IN}),
    .re_i    (rd_en),
    .raddr_i (arr_addr),
    .rdata_o (rdata)
  );

  assign rd_word             = rdata[36:1];
  assign bus.DATA_OUT        = rd_word;
  assign bus.DATA_PAR_OUT    = rdata[0];
  assign bus.MEM_ERROR       = dv_rd_q & (odd_par36(rd_word) != rdata[0]);
  assign bus.ACKN            = ackn_q;
  assign bus.DATA_VALID      = dv_q;
  assign bus.MEM_ADR_PAR_ERR = aperr_q;
  assign bus.BUSY            = (state_q != IDLE);

endmodule
